alu_seq: RTL and testbench

- Parametrised successor to the nic8 8-bit ALU.
- Add and subtract complete in one cycle; add and subtract with carry chain through a registered carry flag.
- Shifts are multi-bit: LSR, ASR and rotate-through-shift-flag, executed one bit per clock under a small FSM with start/busy/done handshake.
- Result is registered and driven onto the shared data bus through an active-low tristate enable; flags are registered for the control unit.

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU.
// Single-cycle add/sub with a registered carry chain, and multi-bit
// LSR/ASR/ROR shifts executed one bit per clock under a start/busy/done
// handshake. The registered result drives the shared data bus through an
// active-low tristate enable.
// Optional feature: define ALU_SEQ_CMP_EN to turn op 111 into CMP
// (flags from A-B, result kept); otherwise op 111 is a NOP that only
// pulses done.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetBar,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] areg,
    input  logic [WIDTH-1:0] breg,
    input  logic [CNT_W-1:0] count,
    input  logic             assertBarE,
    output logic [WIDTH-1:0] dbus,
    output logic             busy,
    output logic             done,
    output logic             flagCarry,
    output logic             flagShift,
    output logic             flagZero,
    output logic             flagNeg,
    output logic             aIsZero
);

    localparam int unsigned SUM_W = WIDTH + 1;
    localparam int unsigned MSB   = WIDTH - 1;

`ifdef ALU_SEQ_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    localparam logic [2:0] OP_CMP = 3'b111;

    // Shift fill selection, taken from op[1:0] of a shift opcode
    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       shift_mode;

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [SUM_W-1:0] sum;
    logic             fill;
    logic [WIDTH-1:0] shift_next;
    logic             last_step;

    // Adder operand and carry-in: subtracts invert B, chained ops use flagCarry
    always_comb begin
        b_eff    = op[0] ? ~breg : breg;
        carry_in = 1'b0;
        if (op == OP_CMP) begin
            b_eff    = ~breg;
            carry_in = 1'b1;
        end else if (op[1]) begin
            carry_in = flagCarry;
        end else begin
            carry_in = op[0];
        end
        sum = SUM_W'(areg) + SUM_W'(b_eff) + SUM_W'(carry_in);
    end

    // One-bit right shift of the working result with mode-dependent fill
    always_comb begin
        fill = 1'b0;
        case (shift_mode)
            MODE_LSR: fill = 1'b0;
            MODE_ASR: fill = result[MSB];
            default:  fill = flagShift;
        endcase
        shift_next = {fill, result[WIDTH-1:1]};
        last_step  = (remaining == CNT_W'(1));
    end

    // Operation sequencer: state, result, flags and handshake registers
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state      <= IDLE;
            result     <= '0;
            remaining  <= '0;
            shift_mode <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flagCarry  <= 1'b0;
            flagShift  <= 1'b0;
            flagZero   <= 1'b0;
            flagNeg    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            result    <= sum[MSB:0];
                            flagCarry <= sum[WIDTH];
                            flagZero  <= (sum[MSB:0] == '0);
                            flagNeg   <= sum[MSB];
                            done      <= 1'b1;
                        end else if (op == OP_CMP) begin
                            if (CMP_EN) begin
                                flagCarry <= sum[WIDTH];
                                flagZero  <= (sum[MSB:0] == '0);
                                flagNeg   <= sum[MSB];
                            end
                            done <= 1'b1;
                        end else begin
                            result     <= areg;
                            remaining  <= count;
                            shift_mode <= op[1:0];
                            if (count == '0) begin
                                flagZero <= (areg == '0);
                                flagNeg  <= areg[MSB];
                                done     <= 1'b1;
                            end else begin
                                state <= SHIFT;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                SHIFT: begin
                    result    <= shift_next;
                    flagShift <= result[0];
                    remaining <= remaining - CNT_W'(1);
                    if (last_step) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        flagZero <= (shift_next == '0);
                        flagNeg  <= shift_next[MSB];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bus driver and operand-A zero detect
    assign dbus    = assertBarE ? 'z : result;
    assign aIsZero = (areg == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized self-checking bench for alu_seq (WIDTH=8, CNT_W=3).
// The reference model computes results with plain integer arithmetic and
// whole-word shifts/rotates rather than bit-serial steps.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       resetBar;
    logic       start;
    logic [2:0] op;
    logic [7:0] areg;
    logic [7:0] breg;
    logic [2:0] count;
    logic       assertBarE;
    wire  [7:0] dbus;
    logic       busy, done, flagCarry, flagShift, flagZero, flagNeg, aIsZero;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0] m_r;
    logic       m_c, m_s, m_z, m_n;

    alu_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .resetBar(resetBar), .start(start), .op(op),
        .areg(areg), .breg(breg), .count(count), .assertBarE(assertBarE),
        .dbus(dbus), .busy(busy), .done(done), .flagCarry(flagCarry),
        .flagShift(flagShift), .flagZero(flagZero), .flagNeg(flagNeg),
        .aIsZero(aIsZero)
    );

    // Released bus is pulled up so it reads all-ones when not driven
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (dbus[g]);
    end

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_r = 8'h00; m_c = 1'b0; m_s = 1'b0; m_z = 1'b0; m_n = 1'b0;
    endfunction

    function automatic void model_op(input logic [2:0] o, input logic [7:0] a,
                                     input logic [7:0] b, input logic [2:0] k);
        int s;
        logic [8:0] w;
        logic signed [7:0] sa;
        logic [7:0] d;
        case (o)
            3'd0: begin s = int'(a) + int'(b);           m_r = 8'(s); m_c = (s > 255); end
            3'd1: begin s = int'(a) - int'(b);           m_r = 8'(s); m_c = (s >= 0);  end
            3'd2: begin s = int'(a) + int'(b) + int'(m_c); m_r = 8'(s); m_c = (s > 255); end
            3'd3: begin s = int'(a) - int'(b) - (m_c ? 0 : 1); m_r = 8'(s); m_c = (s >= 0); end
            3'd4: begin m_r = a >> k; if (k != 0) m_s = a[k-3'd1]; end
            3'd5: begin sa = a; m_r = 8'(sa >>> k); if (k != 0) m_s = a[k-3'd1]; end
            3'd6: begin
                w = {a, m_s};
                w = (w >> k) | (w << (9 - int'(k)));
                m_r = w[8:1];
                m_s = w[0];
            end
            default: begin
`ifdef ALU_SEQ_CMP_EN
                s = int'(a) - int'(b);
                d = 8'(s);
                m_c = (s >= 0);
                m_z = (d == 8'h00);
                m_n = d[7];
`else
                d = 8'h00;
`endif
            end
        endcase
        if (o != 3'd7) begin
            m_z = (m_r == 8'h00);
            m_n = m_r[7];
        end
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [2:0] k);
        return (o[2] && o != 3'd7) ? int'(k) + 1 : 1;
    endfunction

    // Drive one request and wait (bounded) for done; reports timing observations
    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] k, input bit poke,
                         output int lat, output int bcyc, output int overlap);
        op = o; areg = a; breg = b; count = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        areg = 8'($urandom); breg = 8'($urandom); count = 3'($urandom);
        lat = 1; bcyc = 0; overlap = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            if (poke && lat == 1 && busy) begin
                start = 1'b1;
                op = 3'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        overlap = int'(busy);
    endtask

    task automatic test_reset();
        resetBar = 1'b0; start = 1'b0; op = 3'd0; areg = 8'h00; breg = 8'h00;
        count = 3'd0; assertBarE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, flagCarry, flagShift, flagZero, flagNeg, dbus} !== 14'h0) begin
            errors++;
            $display("FAIL reset_state: got %b want all zero",
                     {busy, done, flagCarry, flagShift, flagZero, flagNeg, dbus});
        end
        resetBar = 1'b1;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start_done: got %b want 0", done);
        end
    endtask

    task automatic test_azero();
        areg = 8'h00; #1;
        checks++;
        if (aIsZero !== 1'b1) begin errors++; $display("FAIL aiszero_0: got %b want 1", aIsZero); end
        areg = 8'h40; #1;
        checks++;
        if (aIsZero !== 1'b0) begin errors++; $display("FAIL aiszero_40: got %b want 0", aIsZero); end
    endtask

    task automatic test_add_bus();
        int lat, bc, ov;
        model_op(3'd0, 8'hF0, 8'h20, 3'd0);
        issue(3'd0, 8'hF0, 8'h20, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++;
        if ({dbus, flagCarry, flagZero, flagNeg} !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_result: got %h %b%b%b want 10 100", dbus, flagCarry, flagZero, flagNeg);
        end
        assertBarE = 1'b1; #1;
        checks++;
        if (dbus !== 8'hFF) begin errors++; $display("FAIL bus_release: got %h want ff (pulled)", dbus); end
        assertBarE = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_sub_sbc();
        int lat, bc, ov;
        model_op(3'd1, 8'h05, 8'h05, 3'd0);
        issue(3'd1, 8'h05, 8'h05, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if ({dbus, flagCarry, flagZero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_eq: got %h c%b z%b want 00 c1 z1", dbus, flagCarry, flagZero);
        end
        model_op(3'd3, 8'h00, 8'h01, 3'd0);
        issue(3'd3, 8'h00, 8'h01, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if ({dbus, flagCarry, flagNeg} !== {8'hFF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sbc_borrow: got %h c%b n%b want ff c0 n1", dbus, flagCarry, flagNeg);
        end
    endtask

    task automatic test_asr();
        int lat, bc, ov;
        model_op(3'd5, 8'h81, 8'h00, 3'd3);
        issue(3'd5, 8'h81, 8'h00, 3'd3, 1'b1, lat, bc, ov);
        checks++;
        if (lat !== 4 || bc !== 3 || ov !== 0) begin
            errors++;
            $display("FAIL asr_timing: got lat %0d busy %0d ov %0d want 4 3 0", lat, bc, ov);
        end
        checks++;
        if ({dbus, flagShift, flagNeg} !== {8'hF0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL asr_result: got %h s%b n%b want f0 s0 n1", dbus, flagShift, flagNeg);
        end
    endtask

    task automatic test_ror_lsr0();
        int lat, bc, ov;
        model_op(3'd4, 8'h01, 8'h00, 3'd1);
        issue(3'd4, 8'h01, 8'h00, 3'd1, 1'b0, lat, bc, ov);
        model_op(3'd6, 8'h01, 8'h00, 3'd1);
        issue(3'd6, 8'h01, 8'h00, 3'd1, 1'b0, lat, bc, ov);
        checks++;
        if ({dbus, flagShift} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL ror_through: got %h s%b want 80 s1", dbus, flagShift);
        end
        model_op(3'd4, 8'h00, 8'h00, 3'd0);
        issue(3'd4, 8'h00, 8'h00, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if (lat !== 1 || {dbus, flagZero, flagShift} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL lsr_zero_count: got lat %0d %h z%b s%b want 1 00 z1 s1",
                     lat, dbus, flagZero, flagShift);
        end
    endtask

    task automatic test_reset_midshift();
        int lat, bc, ov;
        op = 3'd4; areg = 8'hA5; breg = 8'h00; count = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        resetBar = 1'b0; #1;
        checks++;
        if ({busy, done, flagCarry, flagShift, flagZero, flagNeg, dbus} !== 14'h0) begin
            errors++;
            $display("FAIL reset_midshift: got %b want all zero",
                     {busy, done, flagCarry, flagShift, flagZero, flagNeg, dbus});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done: got %b want 0", done); end
        resetBar = 1'b1;
        model_reset();
        @(posedge clk); #1;
        model_op(3'd0, 8'h01, 8'h01, 3'd0);
        issue(3'd0, 8'h01, 8'h01, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if (dbus !== 8'h02) begin errors++; $display("FAIL add_after_reset: got %h want 02", dbus); end
    endtask

    task automatic test_op7();
        int lat, bc, ov;
        model_op(3'd0, 8'hF0, 8'h52, 3'd0);
        issue(3'd0, 8'hF0, 8'h52, 3'd0, 1'b0, lat, bc, ov);
        model_op(3'd7, 8'h03, 8'h07, 3'd0);
        issue(3'd7, 8'h03, 8'h07, 3'd0, 1'b0, lat, bc, ov);
        checks++;
        if (lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL op7_timing: got lat %0d busy %0d want 1 0", lat, bc);
        end
`ifdef ALU_SEQ_CMP_EN
        checks++;
        if ({dbus, flagCarry, flagZero, flagNeg} !== {8'h42, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cmp_flags: got %h c%b z%b n%b want 42 c0 z0 n1",
                     dbus, flagCarry, flagZero, flagNeg);
        end
`else
        checks++;
        if ({dbus, flagCarry, flagZero, flagNeg} !== {8'h42, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nop_unchanged: got %h c%b z%b n%b want 42 c1 z0 n0",
                     dbus, flagCarry, flagZero, flagNeg);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL op7_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ov;
        logic [15:0] x, y, sum16;
        logic [7:0]  lo;
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom); y = 16'($urandom);
            sum16 = x + y;
            model_op(3'd0, x[7:0], y[7:0], 3'd0);
            issue(3'd0, x[7:0], y[7:0], 3'd0, 1'b0, lat, bc, ov);
            lo = dbus;
            model_op(3'd2, x[15:8], y[15:8], 3'd0);
            issue(3'd2, x[15:8], y[15:8], 3'd0, 1'b0, lat, bc, ov);
            checks++;
            if ({dbus, lo} !== sum16) begin
                errors++;
                $display("FAIL chain16_%0d: got %h want %h", i, {dbus, lo}, sum16);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, ov;
        logic [2:0] o, k;
        logic [7:0] a, b;
        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom); a = 8'($urandom); b = 8'($urandom); k = 3'($urandom);
            model_op(o, a, b, k);
            issue(o, a, b, k, ($urandom_range(0, 3) == 0), lat, bc, ov);
            checks++;
            if (lat !== exp_lat(o, k) || bc !== exp_lat(o, k) - 1 || ov !== 0) begin
                errors++;
                $display("FAIL rand_timing_%0d op%0d k%0d: got lat %0d busy %0d ov %0d want lat %0d",
                         i, o, k, lat, bc, ov, exp_lat(o, k));
            end
            checks++;
            if ({dbus, flagCarry, flagShift, flagZero, flagNeg} !== {m_r, m_c, m_s, m_z, m_n}) begin
                errors++;
                $display("FAIL rand_state_%0d op%0d a%h b%h k%0d: got %h %b%b%b%b want %h %b%b%b%b",
                         i, o, a, b, k, dbus, flagCarry, flagShift, flagZero, flagNeg,
                         m_r, m_c, m_s, m_z, m_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_azero();
        test_add_bus();
        test_sub_sbc();
        test_asr();
        test_ror_lsr0();
        test_reset_midshift();
        test_op7();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
